// File: rtl/cache_wb_plru.sv
// Write-back, write-allocate, set-associative cache with tree-PLRU replacement.
// Single outstanding miss; a flush walk writes back dirty lines, then invalidates the array.
// Optional macro CACHE_PERF_CNT_EN adds saturating hit/miss counters.
module cache_wb_plru #(
  parameter int A         = 4,
  parameter int B         = 64,
  parameter int C         = 2048,
  parameter int W         = 64,
  parameter int ADDR_BITS = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  output logic                 flush_done_out,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]          hit_cnt_out,
  output logic [31:0]          miss_cnt_out,
`endif
  input  logic                 hc_valid_in,
  output logic                 hc_ready_out,
  input  logic                 hc_we_in,
  input  logic [ADDR_BITS-1:0] hc_addr_in,
  input  logic [W-1:0]         hc_value_in,
  output logic                 hc_valid_out,
  input  logic                 hc_ready_in,
  output logic [ADDR_BITS-1:0] hc_addr_out,
  output logic [W-1:0]         hc_value_out,
  output logic                 lc_valid_out,
  input  logic                 lc_ready_in,
  output logic                 lc_we_out,
  output logic [ADDR_BITS-1:0] lc_addr_out,
  output logic [B*8-1:0]       lc_value_out,
  input  logic                 lc_valid_in,
  output logic                 lc_ready_out,
  input  logic [B*8-1:0]       lc_value_in
);
  localparam int S     = C / (B * A);
  localparam int LW    = B * 8;
  localparam int OB    = $clog2(B);
  localparam int IB    = $clog2(S);
  localparam int WAYB  = $clog2(A);
  localparam int TAGB  = ADDR_BITS - OB - IB;
  localparam int BYTEB = $clog2(W / 8);
  localparam int WPL   = LW / W;
  localparam int WIDXB = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int FIW   = IB + WAYB;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESPOND, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
  } state_t;

  state_t           state;
  logic [LW-1:0]    data  [S][A];
  logic [TAGB-1:0]  tags  [S][A];
  logic [A-1:0]     valid [S];
  logic [A-1:0]     dirty [S];
  logic [A-2:0]     plru  [S];

  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_we;
  logic [W-1:0]         req_data;
  logic [WAYB-1:0]      way_r;
  logic [FIW-1:0]       flush_idx;

  logic [IB-1:0]    req_set;
  logic [TAGB-1:0]  req_tag;
  logic [WIDXB-1:0] req_widx;
  logic [IB-1:0]    fset;
  logic [WAYB-1:0]  fway;
  logic             hit;
  logic [WAYB-1:0]  hit_way;
  logic [WAYB-1:0]  victim;
  logic             clear_all;

  assign req_set  = req_addr[OB +: IB];
  assign req_tag  = req_addr[OB+IB +: TAGB];
  assign req_widx = (WPL > 1) ? req_addr[BYTEB +: WIDXB] : '0;
  assign fset     = flush_idx[WAYB +: IB];
  assign fway     = flush_idx[WAYB-1:0];
  assign hc_ready_out = (state == IDLE) && !flush_in;

  // Each node bit on the path is set to point at the half not containing the accessed way.
  function automatic logic [A-2:0] touch(input logic [A-2:0] bits, input logic [WAYB-1:0] way);
    logic [A-2:0] r;
    int unsigned  node;
    r    = bits;
    node = 1;
    for (int unsigned l = 0; l < WAYB; l++) begin
      r[node-1] = ~way[WAYB-1-l];
      node      = 2 * node + (way[WAYB-1-l] ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] merge(input logic [LW-1:0] line, input logic [WIDXB-1:0] idx,
                                          input logic [W-1:0] word);
    logic [LW-1:0] r;
    r = line;
    r[int'(idx)*W +: W] = word;
    return r;
  endfunction

  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [TAGB-1:0] tag, input logic [IB-1:0] set);
    return ADDR_BITS'({tag, set}) << OB;
  endfunction

  // Tag compare, replacement choice and end-of-flush detection.
  always_comb begin
    int unsigned node;
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    node    = 1;
    for (int unsigned i = 0; i < A; i++) begin
      if (!hit && valid[req_set][i] && tags[req_set][i] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAYB'(i);
      end
    end
    for (int unsigned l = 0; l < WAYB; l++) node = 2 * node + (plru[req_set][node-1] ? 1 : 0);
    victim = WAYB'(node - A);
    // Descending scan so the lowest-index invalid way is the one that sticks.
    for (int unsigned i = 0; i < A; i++) begin
      if (!valid[req_set][A-1-i]) victim = WAYB'(A - 1 - i);
    end
    clear_all = (&flush_idx) &&
                ((state == FLUSH_SCAN && !(valid[fset][fway] && dirty[fset][fway])) ||
                 (state == FLUSH_WB && lc_ready_in));
  end

  // Controller, registered outputs and array updates.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      flush_done_out <= 1'b0;
      hc_valid_out   <= 1'b0;
      hc_addr_out    <= '0;
      hc_value_out   <= '0;
      lc_valid_out   <= 1'b0;
      lc_we_out      <= 1'b0;
      lc_addr_out    <= '0;
      lc_value_out   <= '0;
      lc_ready_out   <= 1'b0;
      req_addr       <= '0;
      req_we         <= 1'b0;
      req_data       <= '0;
      way_r          <= '0;
      flush_idx      <= '0;
      for (int unsigned s = 0; s < S; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
`ifdef CACHE_PERF_CNT_EN
      hit_cnt_out  <= '0;
      miss_cnt_out <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (flush_in) begin
            flush_idx <= '0;
            state     <= FLUSH_SCAN;
          end else if (hc_valid_in) begin
            req_addr <= hc_addr_in;
            req_we   <= hc_we_in;
            req_data <= hc_value_in;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
`ifdef CACHE_PERF_CNT_EN
          if (hit && hit_cnt_out != '1) hit_cnt_out <= hit_cnt_out + 32'd1;
          if (!hit && miss_cnt_out != '1) miss_cnt_out <= miss_cnt_out + 32'd1;
`endif
          if (hit) begin
            plru[req_set] <= touch(plru[req_set], hit_way);
            if (req_we) begin
              data[req_set][hit_way]  <= merge(data[req_set][hit_way], req_widx, req_data);
              dirty[req_set][hit_way] <= 1'b1;
              hc_value_out            <= req_data;
            end else begin
              hc_value_out <= data[req_set][hit_way][int'(req_widx)*W +: W];
            end
            hc_addr_out  <= req_addr;
            hc_valid_out <= 1'b1;
            state        <= RESPOND;
          end else begin
            way_r        <= victim;
            lc_valid_out <= 1'b1;
            if (valid[req_set][victim] && dirty[req_set][victim]) begin
              lc_we_out    <= 1'b1;
              lc_addr_out  <= line_addr(tags[req_set][victim], req_set);
              lc_value_out <= data[req_set][victim];
              state        <= WB_REQ;
            end else begin
              lc_we_out   <= 1'b0;
              lc_addr_out <= line_addr(req_tag, req_set);
              state       <= FILL_REQ;
            end
          end
        end
        WB_REQ: begin
          if (lc_ready_in) begin
            lc_we_out    <= 1'b0;
            lc_addr_out  <= line_addr(req_tag, req_set);
            lc_value_out <= '0;
            state        <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (lc_ready_in) begin
            lc_valid_out <= 1'b0;
            lc_ready_out <= 1'b1;
            state        <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (lc_valid_in) begin
            tags[req_set][way_r]  <= req_tag;
            valid[req_set][way_r] <= 1'b1;
            dirty[req_set][way_r] <= req_we;
            data[req_set][way_r]  <= req_we ? merge(lc_value_in, req_widx, req_data) : lc_value_in;
            plru[req_set]         <= touch(plru[req_set], way_r);
            hc_value_out          <= req_we ? req_data : lc_value_in[int'(req_widx)*W +: W];
            hc_addr_out           <= req_addr;
            hc_valid_out          <= 1'b1;
            lc_ready_out          <= 1'b0;
            state                 <= RESPOND;
          end
        end
        RESPOND: begin
          if (hc_ready_in) begin
            hc_valid_out <= 1'b0;
            state        <= IDLE;
          end
        end
        FLUSH_SCAN: begin
          if (valid[fset][fway] && dirty[fset][fway]) begin
            lc_valid_out <= 1'b1;
            lc_we_out    <= 1'b1;
            lc_addr_out  <= line_addr(tags[fset][fway], fset);
            lc_value_out <= data[fset][fway];
            state        <= FLUSH_WB;
          end else if (&flush_idx) begin
            flush_done_out <= 1'b1;
            state          <= FLUSH_DONE;
          end else begin
            flush_idx <= flush_idx + FIW'(1);
          end
        end
        FLUSH_WB: begin
          if (lc_ready_in) begin
            lc_valid_out <= 1'b0;
            lc_we_out    <= 1'b0;
            if (&flush_idx) begin
              flush_done_out <= 1'b1;
              state          <= FLUSH_DONE;
            end else begin
              flush_idx <= flush_idx + FIW'(1);
              state     <= FLUSH_SCAN;
            end
          end
        end
        FLUSH_DONE: begin
          flush_done_out <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Whole-array invalidate once the walk has passed its last entry.
      if (clear_all) begin
        for (int unsigned s = 0; s < S; s++) begin
          valid[s] <= '0;
          dirty[s] <= '0;
          plru[s]  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_wb_plru.sv
// Randomised and directed bench for cache_wb_plru against a line-level reference model.
module tb_cache_wb_plru;
  localparam int A = 4, B = 64, C = 2048, W = 64, AB = 64;
  localparam int S = C / (B * A), LW = B * 8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, flush_in, flush_done_out;
  logic hc_valid_in, hc_ready_out, hc_we_in, hc_valid_out, hc_ready_in;
  logic [AB-1:0] hc_addr_in, hc_addr_out;
  logic [W-1:0] hc_value_in, hc_value_out;
  logic lc_valid_out, lc_ready_in, lc_we_out, lc_valid_in, lc_ready_out;
  logic [AB-1:0] lc_addr_out;
  logic [LW-1:0] lc_value_out, lc_value_in;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_out, miss_cnt_out;
`endif

  cache_wb_plru #(.A(A), .B(B), .C(C), .W(W), .ADDR_BITS(AB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .flush_done_out(flush_done_out),
`ifdef CACHE_PERF_CNT_EN
    .hit_cnt_out(hit_cnt_out), .miss_cnt_out(miss_cnt_out),
`endif
    .hc_valid_in(hc_valid_in), .hc_ready_out(hc_ready_out), .hc_we_in(hc_we_in),
    .hc_addr_in(hc_addr_in), .hc_value_in(hc_value_in), .hc_valid_out(hc_valid_out),
    .hc_ready_in(hc_ready_in), .hc_addr_out(hc_addr_out), .hc_value_out(hc_value_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_we_out(lc_we_out),
    .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .lc_valid_in(lc_valid_in),
    .lc_ready_out(lc_ready_out), .lc_value_in(lc_value_in)
  );

  int n_checks = 0, n_fail = 0;
  int wb_total = 0;
  longint unsigned last_wb_addr;
  logic [LW-1:0] last_wb_line;

  // Reference model: each way holds a whole line address; lower level is a sparse line store.
  typedef struct { bit v; bit d; longint unsigned la; logic [LW-1:0] dat; } entry_t;
  entry_t mc [S][A];
  bit mplru [S][A-1];
  logic [LW-1:0] lmem [longint unsigned];

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int set_of(longint unsigned a); return int'((a / B) % S); endfunction
  function automatic longint unsigned line_of(longint unsigned a); return a - (a % B); endfunction
  function automatic int word_of(longint unsigned a); return int'((a % B) / (W / 8)); endfunction

  function automatic logic [LW-1:0] get_line(longint unsigned la);
    logic [LW-1:0] l;
    if (!lmem.exists(la)) begin
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      lmem[la] = l;
    end
    return lmem[la];
  endfunction

  function automatic void m_touch(int s, int w);
    int node = 1, span = A, right;
    while (span > 1) begin
      span  = span / 2;
      right = (w / span) % 2;
      mplru[s][node-1] = (right == 0);
      node  = 2 * node + right;
      w     = w % span;
    end
  endfunction

  function automatic int m_victim(int s);
    int node = 1;
    for (int w = 0; w < A; w++) if (!mc[s][w].v) return w;
    while (node < A) node = 2 * node + int'(mplru[s][node-1]);
    return node - A;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < S; s++) begin
      for (int w = 0; w < A; w++) begin mc[s][w].v = 0; mc[s][w].d = 0; end
      for (int n = 0; n < A - 1; n++) mplru[s][n] = 0;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, hc_ready_out, 1);
    check({tag, "_outs"}, {flush_done_out, hc_valid_out, hc_addr_out, hc_value_out,
                           lc_valid_out, lc_we_out, lc_addr_out, lc_ready_out}, '0);
    check({tag, "_lc_value"}, lc_value_out, '0);
  endtask

  task automatic access(input bit we, input longint unsigned addr, input logic [W-1:0] wdata,
                        input int hold, output logic [W-1:0] rdata, output bit was_hit);
    int s, w, way, cyc, g, wbs, fills;
    bit hit, exp_wb, got, lcact, fill_pend;
    longint unsigned la, exp_wb_addr;
    logic [LW-1:0] exp_wb_line, fline, nline;
    logic [W-1:0] exp_val;
    s = set_of(addr); la = line_of(addr); w = word_of(addr);
    hit = 0; way = 0; exp_wb = 0; exp_wb_addr = 0; exp_wb_line = '0;
    for (int i = 0; i < A; i++) if (mc[s][i].v && mc[s][i].la == la) begin hit = 1; way = i; end
    fline = get_line(la);
    if (hit) nline = mc[s][way].dat;
    else begin
      way = m_victim(s);
      exp_wb = mc[s][way].v && mc[s][way].d;
      exp_wb_addr = mc[s][way].la; exp_wb_line = mc[s][way].dat;
      nline = fline;
      mc[s][way].v = 1; mc[s][way].d = 0; mc[s][way].la = la;
    end
    if (we) begin nline[w*W +: W] = wdata; mc[s][way].d = 1; end
    mc[s][way].dat = nline;
    exp_val = nline[w*W +: W];
    m_touch(s, way);
    was_hit = hit;

    g = 0;
    while (!hc_ready_out && g < 50) begin @(posedge clk_in); #1; g++; end
    check("ready_wait", hc_ready_out, 1);
    hc_valid_in = 1; hc_we_in = we; hc_addr_in = addr; hc_value_in = wdata;
    @(posedge clk_in); #1;
    hc_valid_in = 0; hc_value_in = $urandom;
    check("busy_after_accept", hc_ready_out, 0);

    cyc = 0; got = 0; wbs = 0; fills = 0; lcact = 0; fill_pend = 0;
    while (!got && cyc < 400) begin
      lc_ready_in = 0; lc_valid_in = 0; lc_value_in = {16{$urandom}};
      if (hc_valid_out) got = 1;
      else begin
        if (lc_valid_out) begin
          lcact = 1;
          if ($urandom_range(0, 2) != 0) begin
            lc_ready_in = 1;
            if (lc_we_out) begin
              wbs++; wb_total++;
              check("wb_addr", lc_addr_out, exp_wb_addr);
              check("wb_line", lc_value_out, exp_wb_line);
              lmem[lc_addr_out] = lc_value_out;
              last_wb_addr = lc_addr_out; last_wb_line = lc_value_out;
            end else begin
              check("wb_before_fill", wbs, exp_wb);
              check("fill_addr", lc_addr_out, la);
              fill_pend = 1; fills++;
            end
          end
        end else if (lc_ready_out && fill_pend && $urandom_range(0, 1) == 1) begin
          lc_valid_in = 1; lc_value_in = fline; fill_pend = 0;
        end
        @(posedge clk_in); #1; cyc++;
      end
    end
    lc_ready_in = 0; lc_valid_in = 0;
    check("resp_seen", got, 1);
    check("resp_addr", hc_addr_out, addr);
    check("resp_value", hc_value_out, exp_val);
    if (hit) begin
      check("hit_latency", cyc, 1);
      check("hit_no_lc", lcact, 0);
    end else begin
      check("miss_wb_count", wbs, exp_wb);
      check("miss_fill_count", fills, 1);
    end
    rdata = hc_value_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_in); #1;
      check("hold_valid", hc_valid_out, 1);
      check("hold_addr", hc_addr_out, addr);
      check("hold_value", hc_value_out, exp_val);
      check("hold_not_ready", hc_ready_out, 0);
    end
    hc_ready_in = 1;
    @(posedge clk_in); #1;
    hc_ready_in = 0;
    check("resp_released", hc_valid_out, 0);
    check("idle_ready", hc_ready_out, 1);
  endtask

  task automatic do_flush(output int n_wb);
    longint unsigned qa[$];
    logic [LW-1:0] ql[$];
    int cyc, exp_n;
    bit done;
    for (int s = 0; s < S; s++)
      for (int w = 0; w < A; w++)
        if (mc[s][w].v && mc[s][w].d) begin qa.push_back(mc[s][w].la); ql.push_back(mc[s][w].dat); end
    exp_n = qa.size();
    flush_in = 1;
    @(posedge clk_in); #1;
    flush_in = 0;
    check("flush_busy", hc_ready_out, 0);
    n_wb = 0; cyc = 0; done = 0;
    while (!done && cyc < 1000) begin
      lc_ready_in = 0;
      if (flush_done_out) done = 1;
      else begin
        if (lc_valid_out && $urandom_range(0, 1) == 1) begin
          lc_ready_in = 1;
          check("flush_wb_we", lc_we_out, 1);
          if (qa.size() > 0) begin
            check("flush_wb_addr", lc_addr_out, qa.pop_front());
            check("flush_wb_line", lc_value_out, ql.pop_front());
          end
          lmem[lc_addr_out] = lc_value_out;
          n_wb++;
        end
        @(posedge clk_in); #1; cyc++;
      end
    end
    lc_ready_in = 0;
    check("flush_done_seen", done, 1);
    check("flush_wb_count", n_wb, exp_n);
    @(posedge clk_in); #1;
    check("flush_done_one_cycle", flush_done_out, 0);
    check("ready_after_flush", hc_ready_out, 1);
    m_clear();
  endtask

  initial begin
    logic [W-1:0] rd;
    bit h;
    int nwb, wb0, g;
    rst_in = 1; flush_in = 0; hc_valid_in = 0; hc_we_in = 0; hc_addr_in = '0; hc_value_in = '0;
    hc_ready_in = 0; lc_ready_in = 0; lc_valid_in = 0; lc_value_in = '0;
    m_clear();
    lmem[64'h1000] = {64{8'hAA}};
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 0;
    @(posedge clk_in); #1;

    access(0, 64'h1000, '0, 0, rd, h);
    check("cold_miss", h, 0);
    check("cold_value", rd, 64'hAAAAAAAAAAAAAAAA);
    access(0, 64'h1000, '0, 0, rd, h);
    check("repeat_hit", h, 1);
`ifdef CACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt_out, 1);
    check("miss_cnt", miss_cnt_out, 1);
`endif
    access(1, 64'h1008, 64'hDEAD, 0, rd, h);
    check("write_hit", h, 1);
    wb0 = wb_total;
    access(0, 64'h1200, '0, 0, rd, h);
    access(0, 64'h1400, '0, 0, rd, h);
    access(0, 64'h1600, '0, 0, rd, h);
    access(0, 64'h1800, '0, 0, rd, h);
    check("evict_one_wb", wb_total - wb0, 1);
    check("evict_wb_addr", last_wb_addr, 64'h1000);
    check("evict_wb_word", last_wb_line[64 +: 64], 64'hDEAD);

    access(0, 64'h1000, '0, 10, rd, h);

    do_flush(nwb);
    access(1, 64'h2000, 64'h1111, 0, rd, h);
    access(1, 64'h3048, 64'h2222, 0, rd, h);
    do_flush(nwb);
    check("flush_two_wb", nwb, 2);
    access(0, 64'h2000, '0, 0, rd, h);
    check("post_flush_miss_a", h, 0);
    access(0, 64'h3048, '0, 0, rd, h);
    check("post_flush_miss_b", h, 0);
    access(0, 64'h3048, '0, 0, rd, h);
    check("prior_hit", h, 1);

    // Cold miss in set 1, reset while the fill is outstanding.
    hc_valid_in = 1; hc_we_in = 0; hc_addr_in = 64'h5040;
    @(posedge clk_in); #1;
    hc_valid_in = 0;
    g = 0;
    while (!lc_ready_out && g < 100) begin
      lc_ready_in = lc_valid_out;
      @(posedge clk_in); #1;
      lc_ready_in = 0; g++;
    end
    check("reached_fill_wait", lc_ready_out, 1);
    rst_in = 1;
    @(posedge clk_in); #1;
    rst_in = 0;
    check_reset_outputs("mid_reset");
    m_clear();
    access(0, 64'h3048, '0, 0, rd, h);
    check("after_reset_miss", h, 0);

    for (int i = 0; i < 300; i++) begin
      longint unsigned a;
      a = 64'h10000 + longint'($urandom_range(0, 5)) * 64'h200 + longint'($urandom_range(0, 7)) * 64
          + longint'($urandom_range(0, 7)) * 8;
      access($urandom_range(0, 1) == 1, a, {$urandom, $urandom}, $urandom_range(0, 2), rd, h);
      if (i % 100 == 99) do_flush(nwb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
